// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Widest operand the magnitude helper supports; callers sign-extend into it.
    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x);
        return x[MAX_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic           ge;

    assign shifted = {rem_i, q_i[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, divisor_i});
    // A kept difference is always below the divisor, so it fits in WIDTH bits.
    assign rem_o   = ge ? WIDTH'(shifted - {1'b0, divisor_i}) : shifted[WIDTH-1:0];
    assign q_o     = {q_i[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU/REM/REMU) with valid/ready on both sides.
//   state | meaning
//   IDLE  | waiting for a request, in_ready = ~flush
//   BUSY  | one quotient bit per cycle, cnt counts down from WIDTH
//   DONE  | result held on the outputs until out_ready
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             is_signed_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o,
    output logic             overflow_o,
    output logic             busy_o
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             sgn, a_neg, b_neg, accept;
    logic [WIDTH-1:0] a_mag, b_mag, step_rem, step_q;

    assign sgn   = SIGNED_EN & is_signed_i;
    assign a_neg = sgn & dividend_i[WIDTH-1];
    assign b_neg = sgn & divisor_i[WIDTH-1];
    // abs_val(MIN) is 2^(W-1), which is the right unsigned magnitude.
    assign a_mag = WIDTH'(abs_val({{(MAX_W-WIDTH){a_neg}}, dividend_i}));
    assign b_mag = WIDTH'(abs_val({{(MAX_W-WIDTH){b_neg}}, divisor_i}));

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .q_i       (q_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign in_ready_o = (state_q == IDLE) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    ovf_d = 1'b0;
                    if (divisor_i == '0) begin
                        q_d     = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (sgn && dividend_i == MIN_VAL && divisor_i == '1) begin
                        q_d     = MIN_VAL;
                        rem_d   = '0;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = a_mag;
                        rem_d   = '0;
                        dvs_d   = b_mag;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                q_d   = step_q;
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Sign fix-up on the final iteration so DONE holds the finished result.
                    if (neg_q_q) q_d = -step_q;
                    if (neg_r_q) rem_d = -step_rem;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid_o   = (state_q == DONE);
    assign busy_o        = (state_q != IDLE);
    assign quotient_o    = q_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;

endmodule
